// File: rtl/pmem_pkg.sv
// Shared constants and types for the physical-memory burst responder.
package pmem_pkg;

   localparam int unsigned PMEM_BEATS     = 8;
   localparam int unsigned PMEM_WORD_BITS = 32;
   localparam int unsigned PMEM_LINE_BITS = 256;

   typedef logic [2:0] pmem_beat_t;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StBurst,
      StDone
   } pmem_state_t;

endpackage

// File: rtl/pmem_word_ram.sv
// Single-port synchronous word RAM with one-cycle read latency (BRAM style, no reset).
module pmem_word_ram
   import pmem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 13
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [PMEM_WORD_BITS-1:0] wdata,
   output logic [PMEM_WORD_BITS-1:0] rdata
);

   logic [PMEM_WORD_BITS-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/pmem_burst_responder.sv
// Line-sized read/write responder: fixed latency, then an 8-beat burst from local RAM.
// Optional PMEM_CRITICAL_WORD_FIRST_EN starts the burst at mem_addr[4:2] and wraps in the line.
module pmem_burst_responder
   import pmem_pkg::*;
#(
   parameter int unsigned LINE_ADDR_WIDTH = 10,
   parameter int unsigned LATENCY         = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mem_read,
   input  logic                      mem_write,
   input  logic [31:0]               mem_addr,
   input  logic [PMEM_WORD_BITS-1:0] mem_wdata,
   output logic [PMEM_WORD_BITS-1:0] mem_rdata,
   output logic                      mem_resp
);

   localparam int unsigned RamAw   = LINE_ADDR_WIDTH + 3;
   localparam logic [3:0]  LatLoad = 4'(LATENCY - 1);

   pmem_state_t                state_q;
   logic [3:0]                 lat_cnt_q;
   pmem_beat_t                 beat_q;
   pmem_beat_t                 num_q;
   logic [LINE_ADDR_WIDTH-1:0] line_q;
   logic                       is_write_q;
   logic                       resp_q;

   logic                       req;
   pmem_beat_t                 start_beat;
   pmem_beat_t                 ram_word;
   logic [RamAw-1:0]           ram_addr;
   logic                       ram_we;
   logic [PMEM_WORD_BITS-1:0]  ram_rdata;
   logic                       unused_addr;

   assign req         = mem_read | mem_write;
   assign unused_addr = ^{mem_addr[31:LINE_ADDR_WIDTH+5], mem_addr[4:0]};

`ifdef PMEM_CRITICAL_WORD_FIRST_EN
   assign start_beat = mem_addr[4:2];
`else
   assign start_beat = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         lat_cnt_q  <= '0;
         beat_q     <= '0;
         num_q      <= '0;
         line_q     <= '0;
         is_write_q <= 1'b0;
         resp_q     <= 1'b0;
      end else begin
         unique case (state_q)
            // DONE is the dead cycle; its closing edge may already accept the next request.
            StIdle, StDone: begin
               resp_q <= 1'b0;
               if (req) begin
                  line_q     <= mem_addr[LINE_ADDR_WIDTH+4:5];
                  beat_q     <= start_beat;
                  num_q      <= '0;
                  is_write_q <= mem_write;
                  lat_cnt_q  <= LatLoad;
                  state_q    <= (LATENCY == 1) ? StBurst : StWait;
               end else begin
                  state_q <= StIdle;
               end
            end
            StWait: begin
               if (!req) begin
                  state_q <= StIdle;
               end else if (lat_cnt_q <= 4'd1) begin
                  lat_cnt_q <= '0;
                  state_q   <= StBurst;
               end else begin
                  lat_cnt_q <= lat_cnt_q - 4'd1;
               end
            end
            // First BURST cycle only primes the RAM; beats are strobed from the next one.
            StBurst: begin
               if (!req) begin
                  resp_q  <= 1'b0;
                  state_q <= StIdle;
               end else if (!resp_q) begin
                  resp_q <= 1'b1;
               end else if (num_q == 3'd7) begin
                  resp_q  <= 1'b0;
                  state_q <= StDone;
               end else begin
                  num_q  <= num_q + 3'd1;
                  beat_q <= beat_q + 3'd1;
               end
            end
            default: begin
               resp_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Reads address the next beat so the RAM output lines up with the strobe.
   always_comb begin
      ram_word = beat_q;
      if (!is_write_q && resp_q) begin
         ram_word = beat_q + 3'd1;
      end
   end

   assign ram_addr  = {line_q, ram_word};
   assign mem_resp  = resp_q & req;
   assign ram_we    = mem_resp & is_write_q;
   assign mem_rdata = mem_resp ? ram_rdata : '0;

   pmem_word_ram #(
      .ADDR_WIDTH(RamAw)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (mem_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Self-checking bench: directed scenarios plus randomized bursts against a word-map model.
module tb_pmem_burst_responder;

   localparam int unsigned LAW = 10;
   localparam int unsigned LAT = 4;
`ifdef PMEM_CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   pmem_burst_responder #(
      .LINE_ADDR_WIDTH(LAW),
      .LATENCY        (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_resp  (mem_resp)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model: word index -> contents, and per-cycle expected strobe / read data.
   logic [31:0] mem_model [int unsigned];
   logic        exp_resp  [int unsigned];
   logic [31:0] exp_data  [int unsigned];
   logic [31:0] wbuf      [8];
   logic [31:0] cap_data  [$];
   int unsigned cap_cyc   [$];

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
   endtask

   logic want_resp;
   always @(negedge clk) begin
      if (rst) begin
         check("reset_resp", {31'b0, mem_resp}, 32'd0);
         check("reset_rdata", mem_rdata, 32'd0);
      end else begin
         want_resp = exp_resp.exists(cyc) ? exp_resp[cyc] : 1'b0;
         check("resp", {31'b0, mem_resp}, {31'b0, want_resp});
         if (want_resp && exp_data.exists(cyc)) check("rdata", mem_rdata, exp_data[cyc]);
         if (mem_resp) begin
            cap_data.push_back(mem_rdata);
            cap_cyc.push_back(cyc);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called #1 after an edge with the DUT able to accept at the next edge. n_beats < 8 cuts the
   // burst short, by dropping the request or (by_reset) by an asynchronous reset in that beat.
   task automatic burst(input bit wr, input bit rd, input logic [31:0] addr, input int n_beats,
                        input bit by_reset, output int unsigned acc);
      int unsigned c0, first, idx;
      logic [2:0] start, b;
      logic [LAW-1:0] line;
      c0    = cyc;
      acc   = c0 + 1;
      first = acc + LAT;
      start = CWF ? addr[4:2] : 3'd0;
      line  = addr[LAW+4:5];
      for (int k = 0; k < n_beats; k++) begin
         b   = start + 3'(k);
         idx = 32'(line) * 8 + 32'(b);
         exp_resp[first + 32'(k)] = 1'b1;
         if (wr) mem_model[idx] = wbuf[k];
         else if (mem_model.exists(idx)) exp_data[first + 32'(k)] = mem_model[idx];
      end
      mem_write = wr;
      mem_read  = rd;
      mem_addr  = addr;
      mem_wdata = wbuf[0];
      while (cyc < first + 32'(n_beats)) begin
         @(posedge clk);
         #1;
         if (cyc >= first && cyc < first + 8) mem_wdata = wbuf[cyc - first];
      end
      if (n_beats < 8 && by_reset) begin
         #1 rst = 1'b1;
         #1 check("async_resp_drop", {31'b0, mem_resp}, 32'd0);
         mem_read  = 1'b0;
         mem_write = 1'b0;
         @(posedge clk);
         #1 rst = 1'b0;
      end else begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
         if (n_beats < 8) idle(1);
      end
   endtask

   int unsigned acc, acc2;
   logic [31:0] a;
   logic [LAW-1:0] lines [6];
   int r, n;
   bit wr, rd;

   initial begin
      rst       = 1'b1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         mem_read  = 1'($urandom);
         mem_write = 1'($urandom);
         mem_addr  = $urandom;
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      rst       = 1'b0;
      idle(1);

      // Write line 0x20 then read it back.
      for (int k = 0; k < 8; k++) wbuf[k] = 32'h1111_1111 * 32'(k + 1);
      burst(1'b1, 1'b0, 32'h0000_0400, 8, 1'b0, acc);
      idle(1);
      cap_data.delete();
      cap_cyc.delete();
      burst(1'b0, 1'b1, 32'h0000_0400, 8, 1'b0, acc);
      idle(1);
      check("wr_rd_beats", 32'(cap_data.size()), 32'd8);
      if (cap_cyc.size() > 0) check("rd_first_latency", 32'(cap_cyc[0] - acc), 32'd4);
      for (int k = 0; k < cap_data.size() && k < 8; k++)
         check("wr_rd_data", cap_data[k], 32'h1111_1111 * 32'(k + 1));

      // Read abandoned after three beats.
      cap_data.delete();
      burst(1'b0, 1'b1, 32'h0000_0400, 3, 1'b0, acc);
      idle(2);
      check("abort_beats", 32'(cap_data.size()), 32'd3);

      // Reset lands in write beat 5: beats 0-4 new, 5-7 old.
      for (int k = 0; k < 8; k++) wbuf[k] = 32'hA000_0000 + 32'(k);
      burst(1'b1, 1'b0, 32'h0000_0400, 5, 1'b1, acc);
      idle(1);
      cap_data.delete();
      burst(1'b0, 1'b1, 32'h0000_0400, 8, 1'b0, acc);
      idle(1);
      check("rst_mid_beats", 32'(cap_data.size()), 32'd8);
      for (int k = 0; k < cap_data.size() && k < 8; k++)
         check("rst_mid_data", cap_data[k],
               (k < 5) ? 32'hA000_0000 + 32'(k) : 32'h1111_1111 * 32'(k + 1));

      // Both requests high: write wins.
      for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
      burst(1'b1, 1'b1, 32'h0000_0040, 8, 1'b0, acc);
      idle(1);
      cap_data.delete();
      burst(1'b0, 1'b1, 32'h0000_0040, 8, 1'b0, acc);
      idle(1);
      for (int k = 0; k < cap_data.size() && k < 8; k++) check("both_req_data", cap_data[k], wbuf[k]);

      // Line preloaded with its beat index, read at 0x34.
      for (int k = 0; k < 8; k++) wbuf[k] = 32'(k);
      burst(1'b1, 1'b0, 32'h0000_0020, 8, 1'b0, acc);
      idle(1);
      cap_data.delete();
      burst(1'b0, 1'b1, 32'h0000_0034, 8, 1'b0, acc);
      idle(1);
      check("cwf_beats", 32'(cap_data.size()), 32'd8);
      for (int k = 0; k < cap_data.size() && k < 8; k++)
         check("cwf_order", cap_data[k], CWF ? 32'((k + 5) % 8) : 32'(k));

      // Back-to-back reads: request re-raised in the DONE cycle.
      cap_data.delete();
      cap_cyc.delete();
      burst(1'b0, 1'b1, 32'h0000_0400, 8, 1'b0, acc);
      burst(1'b0, 1'b1, 32'h0000_0040, 8, 1'b0, acc2);
      idle(2);
      check("b2b_beats", 32'(cap_cyc.size()), 32'd16);
      if (cap_cyc.size() >= 9) begin
         check("b2b_dead_cycle", 32'(acc2 - cap_cyc[7]), 32'd2);
         check("b2b_gap", 32'(cap_cyc[8] - cap_cyc[7]), 32'(LAT + 2));
      end

      // Randomized traffic over a handful of lines with junk in the ignored address bits.
      for (int i = 0; i < 6; i++) lines[i] = LAW'($urandom);
      for (int t = 0; t < 40; t++) begin
         a = $urandom;
         a[LAW+4:5] = lines[(t < 6) ? t : $urandom_range(5, 0)];
         for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
         r  = $urandom_range(9, 0);
         wr = (t < 6) || (r < 6);
         rd = (t >= 6) && (r >= 4);
         n  = (t >= 6 && $urandom_range(7, 0) == 0) ? $urandom_range(7, 0) : 8;
         burst(wr, rd, a, n, 1'b0, acc);
         idle($urandom_range(2, 0));
      end
      idle(3);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
